// File: rtl/datapath_ctrl_pkg.sv
// Shared encodings for datapath_controller: FSM states, instruction classes, ALU op codes,
// instruction field positions and the registered decode record.
package datapath_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] CLS_ALU_RR = 3'b000;
    localparam logic [2:0] CLS_ALU_RI = 3'b001;
    localparam logic [2:0] CLS_LOAD   = 3'b010;
    localparam logic [2:0] CLS_STORE  = 3'b011;
    localparam logic [2:0] CLS_BRANCH = 3'b100;
    localparam logic [2:0] CLS_HALT   = 3'b111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MULT = 3'b001;
    localparam logic [2:0] ALU_DIV  = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_COPY = 3'b111;

    localparam int FLD_CLS_LSB = 29;
    localparam int FLD_OP_LSB  = 26;
    localparam int FLD_Y1_LSB  = 22;
    localparam int FLD_A_LSB   = 18;
    localparam int FLD_C_LSB   = 14;
    localparam int FLD_IMM_LSB = 0;
    localparam int IMM_W       = 14;
    localparam int REG_W       = 4;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_Y1   = 2'b01;

    typedef struct packed {
        logic [2:0]       op;
        logic [REG_W-1:0] y1;
        logic [REG_W-1:0] a;
        logic [REG_W-1:0] c;
        logic [IMM_W-1:0] imm;
        logic             is_alu;
        logic             is_imm;
        logic             is_load;
        logic             is_store;
        logic             is_branch;
        logic             is_halt;
        logic             is_illegal;
    } dec_t;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/datapath_controller_instr_decode.sv
// instr_decode: splits an instruction word into fields and class flags, flags illegal classes.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module instr_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec,
    output logic        stall_op
);

    logic [2:0] cls;

    always_comb begin
        cls            = instr[FLD_CLS_LSB +: 3];
        dec            = '0;
        dec.op         = instr[FLD_OP_LSB +: 3];
        dec.y1         = instr[FLD_Y1_LSB +: REG_W];
        dec.a          = instr[FLD_A_LSB +: REG_W];
        dec.c          = instr[FLD_C_LSB +: REG_W];
        dec.imm        = instr[FLD_IMM_LSB +: IMM_W];
        dec.is_alu     = (cls == CLS_ALU_RR) || (cls == CLS_ALU_RI);
        dec.is_imm     = (cls == CLS_ALU_RI);
        dec.is_load    = (cls == CLS_LOAD);
        dec.is_store   = (cls == CLS_STORE);
        dec.is_branch  = (cls == CLS_BRANCH);
        dec.is_halt    = (cls == CLS_HALT);
        // Anything not matching a known class (101/110) is illegal.
        dec.is_illegal = !(dec.is_alu || dec.is_load || dec.is_store ||
                           dec.is_branch || dec.is_halt);
    end

    assign stall_op = dec.is_alu && is_muldiv(dec.op);

endmodule

// File: rtl/datapath_controller.sv
// datapath_controller: FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath controls (optional DATAPATH_CTRL_MULDIV_STALL_EN).
// Latency: 4 cycles per ALU/BRANCH/illegal instr at zero-wait fetch, 5 + wait cycles for LOAD/STORE.
// Backpressure: holds FETCH until instr_ack and MEM until mem_ack; MULT/DIV may stretch EXEC.
module datapath_controller #(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        instr_req,
    input  logic        instr_ack,
    input  logic [31:0] instr,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic        condition,
    output logic        pc_inc,
    output logic        jump,
    output logic [2:0]  alu_op,
    output logic [2:0]  compare_op,
    output logic [3:0]  A,
    output logic [3:0]  C,
    output logic [3:0]  Y1,
    output logic [1:0]  write,
    output logic        const_c,
    output logic [31:0] constant,
    output logic        ld,
    output logic [3:0]  mem_loca_addr,
    output logic        halted,
    output logic        illegal
);
    import datapath_ctrl_pkg::*;

    localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);
`ifdef DATAPATH_CTRL_MULDIV_STALL_EN
    localparam logic [CNT_W-1:0] MULDIV_EXTRA = CNT_W'(MULDIV_CYCLES - 1);
`else
    localparam logic [CNT_W-1:0] MULDIV_EXTRA = '0;
`endif

    state_t           state_q, state_d;
    logic [31:0]      ir_q;
    dec_t             dec, fld_q;
    logic             stall_op;
    logic             sel_vld_q;
    logic [CNT_W-1:0] cnt_q;

    logic             instr_req_d, mem_req_d, mem_we_d, ld_d;
    logic             pc_inc_d, jump_d, illegal_d, halted_d, wb_d, taken;
    logic [1:0]       write_d;
    logic [3:0]       mem_addr_d;

    instr_decode u_decode (
        .instr    (ir_q),
        .dec      (dec),
        .stall_op (stall_op)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (instr_ack) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    if (fld_q.is_halt)                        state_d = ST_HALT;
                    else if (fld_q.is_load || fld_q.is_store) state_d = ST_MEM;
                    else                                      state_d = ST_WB;
                end
            end
            ST_MEM:    if (mem_ack) state_d = ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase

        // Strobes are registered from the next state so each lines up with its state cycle.
        instr_req_d = (state_d == ST_FETCH);
        mem_req_d   = (state_d == ST_MEM);
        mem_we_d    = mem_req_d && fld_q.is_store;
        mem_addr_d  = mem_req_d ? fld_q.a : '0;
        wb_d        = (state_d == ST_WB);
        taken       = fld_q.is_branch && condition;
        write_d     = (wb_d && (fld_q.is_alu || fld_q.is_load)) ? WR_Y1 : WR_NONE;
        ld_d        = wb_d && fld_q.is_load;
        jump_d      = wb_d && taken;
        pc_inc_d    = wb_d && !taken;
        illegal_d   = wb_d && fld_q.is_illegal;
        halted_d    = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_FETCH;
            ir_q          <= '0;
            fld_q         <= '0;
            sel_vld_q     <= 1'b0;
            cnt_q         <= '0;
            instr_req     <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_loca_addr <= '0;
            write         <= WR_NONE;
            ld            <= 1'b0;
            pc_inc        <= 1'b0;
            jump          <= 1'b0;
            illegal       <= 1'b0;
            halted        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && instr_ack) ir_q <= instr;
            if (state_q == ST_DECODE) begin
                fld_q <= dec;
                cnt_q <= stall_op ? MULDIV_EXTRA : '0;
            end else if (state_q == ST_EXEC && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            sel_vld_q     <= (state_d == ST_EXEC) || (state_d == ST_MEM) || (state_d == ST_WB);
            instr_req     <= instr_req_d;
            mem_req       <= mem_req_d;
            mem_we        <= mem_we_d;
            mem_loca_addr <= mem_addr_d;
            write         <= write_d;
            ld            <= ld_d;
            pc_inc        <= pc_inc_d;
            jump          <= jump_d;
            illegal       <= illegal_d;
            halted        <= halted_d;
        end
    end

    // Selects come straight from the decode register while an instruction is in EXEC..WB.
    assign A          = sel_vld_q ? fld_q.a  : '0;
    assign C          = sel_vld_q ? fld_q.c  : '0;
    assign Y1         = sel_vld_q ? fld_q.y1 : '0;
    assign alu_op     = (sel_vld_q && fld_q.is_alu)    ? fld_q.op : '0;
    assign compare_op = (sel_vld_q && fld_q.is_branch) ? fld_q.op : '0;
    assign const_c    = sel_vld_q && fld_q.is_imm;
    assign constant   = sel_vld_q ? {{(32-IMM_W){1'b0}}, fld_q.imm} : '0;

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench for datapath_controller: scoreboard of expected write-back results,
// popped and compared whenever the controller issues its PC strobe.
module tb_datapath_controller;

    localparam int MULDIV_CYCLES = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_req, instr_ack = 1'b0;
    logic [31:0] instr = '0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic        condition = 1'b0;
    logic        pc_inc, jump;
    logic [2:0]  alu_op, compare_op;
    logic [3:0]  A, C, Y1;
    logic [1:0]  write;
    logic        const_c;
    logic [31:0] constant;
    logic        ld;
    logic [3:0]  mem_loca_addr;
    logic        halted, illegal;

    datapath_controller #(.MULDIV_CYCLES(MULDIV_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_req(instr_req), .instr_ack(instr_ack), .instr(instr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .condition(condition), .pc_inc(pc_inc), .jump(jump),
        .alu_op(alu_op), .compare_op(compare_op), .A(A), .C(C), .Y1(Y1),
        .write(write), .const_c(const_c), .constant(constant), .ld(ld),
        .mem_loca_addr(mem_loca_addr), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  op;
        logic [3:0]  y1, a, c;
        logic [31:0] k;
        logic [1:0]  wr;
        logic        ld, jmp, pci, ill, cc;
        int          wb_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] cls, input logic [2:0] op,
                                       input logic [3:0] y1, input logic [3:0] a,
                                       input logic [3:0] c, input logic [13:0] imm);
        return {cls, op, y1, a, c, imm};
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic cnd);
        exp_t e;
        logic [2:0] cls;
        cls      = w[31:29];
        e.cls    = cls;
        e.op     = w[28:26];
        e.y1     = w[25:22];
        e.a      = w[21:18];
        e.c      = w[17:14];
        e.k      = {18'd0, w[13:0]};
        e.wr     = (cls == 3'd0 || cls == 3'd1 || cls == 3'd2) ? 2'b01 : 2'b00;
        e.ld     = (cls == 3'd2);
        e.ill    = (cls == 3'd5 || cls == 3'd6);
        e.jmp    = (cls == 3'd4) && cnd;
        e.pci    = !e.jmp;
        e.cc     = (cls == 3'd1);
        e.wb_cyc = 0;
        return e;
    endfunction

    function automatic logic outs_nz();
        return |{instr_req, mem_req, mem_we, pc_inc, jump, alu_op, compare_op, A, C, Y1,
                 write, const_c, constant, ld, mem_loca_addr, halted, illegal};
    endfunction

    // Write-back monitor: every PC strobe retires the oldest expected instruction.
    always @(negedge clk) begin
        if (pc_inc && jump) check("pc_inc_and_jump", 1, 0);
        if (!pc_inc && !jump && (write != 2'b00 || ld || illegal)) check("stray_strobe", 1, 0);
        if (pc_inc || jump) begin
            if (sb.size() == 0) begin
                check("unexpected_wb", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_cycle", cyc, mon_e.wb_cyc);
                check("write", write, mon_e.wr);
                check("ld", ld, mon_e.ld);
                check("jump", jump, mon_e.jmp);
                check("pc_inc", pc_inc, mon_e.pci);
                check("illegal", illegal, mon_e.ill);
                check("const_c", const_c, mon_e.cc);
                if (mon_e.wr != 2'b00) check("Y1", Y1, mon_e.y1);
                if (mon_e.cls <= 3'd1) begin
                    check("alu_op", alu_op, mon_e.op);
                    check("A", A, mon_e.a);
                end
                if (mon_e.cls == 3'd0) check("C", C, mon_e.c);
                if (mon_e.cls == 3'd1) check("constant", constant, mon_e.k);
                if (mon_e.cls == 3'd4) check("compare_op", compare_op, mon_e.op);
            end
        end
    end

    task automatic wait_fetch(output logic ok);
        int n = 0;
        while (!instr_req && n < 64) begin @(negedge clk); n++; end
        ok = instr_req;
        if (!ok) check("fetch_req_timeout", 0, 1);
    endtask

    task automatic run_instr(input logic [31:0] w, input logic cnd, input int fwait, input int mwait);
        exp_t       e;
        logic       ok;
        int         n, lat;
        logic [2:0] cls, op;
        cls = w[31:29];
        op  = w[28:26];
        wait_fetch(ok);
        if (!ok) return;
        lat = 4 + fwait;
        if (cls == 3'd2 || cls == 3'd3) lat += 1 + mwait;
`ifdef DATAPATH_CTRL_MULDIV_STALL_EN
        if (cls <= 3'd1 && (op == 3'b001 || op == 3'b101)) lat += MULDIV_CYCLES - 1;
`endif
        e        = model(w, cnd);
        e.wb_cyc = cyc + lat - 1;
        sb.push_back(e);
        condition = ~cnd;
        instr     = ~w;
        repeat (fwait) @(negedge clk);
        instr     = w;
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        instr     = $urandom;
        if (cls == 3'd2 || cls == 3'd3) begin
            n = 0;
            while (!mem_req && n < 8) begin @(negedge clk); n++; end
            n = 0;
            instr_ack = 1'b1;   // must be ignored outside FETCH
            while (mem_req && n < 32) begin
                if (n == 0) begin
                    check("mem_loca_addr", mem_loca_addr, e.a);
                    check("mem_we", mem_we, (cls == 3'd3));
                end
                n++;
                mem_ack = (n == mwait + 1);
                @(negedge clk);
            end
            mem_ack   = 1'b0;
            instr_ack = 1'b0;
            check("mem_req_cycles", n, mwait + 1);
        end else begin
            mem_ack = 1'b1;     // must be ignored outside MEM
            @(negedge clk);
            condition = cnd;    // only the last EXEC cycle value counts
            @(negedge clk);
            mem_ack   = 1'b0;
            condition = ~cnd;
        end
    endtask

    task automatic reset_dut(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            check("rst_outs_zero", outs_nz(), 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_release_instr_req", instr_req, 1);
        check("rst_release_no_write", write, 0);
        check("rst_release_mem_req", mem_req, 0);
    endtask

    task automatic run_halt();
        logic ok;
        int   n, bad;
        wait_fetch(ok);
        if (!ok) return;
        instr     = mk(3'd7, 3'd0, 4'd0, 4'd0, 4'd0, 14'd0);
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        n = 0;
        while (!halted && n < 8) begin @(negedge clk); n++; end
        check("halt_reached", halted, 1);
        bad       = 0;
        instr     = mk(3'd1, 3'd0, 4'd3, 4'd1, 4'd0, 14'd9);
        instr_ack = 1'b1;
        mem_ack   = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (instr_req || !halted || pc_inc || jump || write != 2'b00 || mem_req || illegal) bad++;
        end
        instr_ack = 1'b0;
        mem_ack   = 1'b0;
        check("halt_hold_bad_cycles", bad, 0);
    endtask

    task automatic reset_mid_mem();
        logic ok;
        int   n = 0;
        wait_fetch(ok);
        if (!ok) return;
        instr     = mk(3'd2, 3'd0, 4'd5, 4'd2, 4'd0, 14'd0);
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        while (!mem_req && n < 8) begin @(negedge clk); n++; end
        check("rm_mem_reached", mem_req, 1);
        reset_dut(3);
    endtask

    initial begin
        logic [31:0] w;
        reset_dut(3);
        run_instr(mk(3'd1, 3'b000, 4'd3, 4'd1, 4'd0, 14'd9), 1'b0, 0, 0);   // ADD imm
        run_instr(mk(3'd0, 3'b100, 4'd7, 4'd2, 4'd4, 14'd0), 1'b0, 0, 0);   // SUB reg
        run_instr(mk(3'd0, 3'b001, 4'd1, 4'd3, 4'd5, 14'd0), 1'b0, 0, 0);   // MULT
        run_instr(mk(3'd1, 3'b101, 4'd2, 4'd6, 4'd0, 14'h3FFF), 1'b0, 0, 0); // DIV imm
        run_instr(mk(3'd0, 3'b111, 4'd15, 4'd14, 4'd13, 14'd0), 1'b0, 1, 0); // COPY, fetch wait
        run_instr(mk(3'd2, 3'd0, 4'd5, 4'd2, 4'd0, 14'd0), 1'b0, 0, 3);     // LOAD, mem wait 3
        run_instr(mk(3'd3, 3'd0, 4'd0, 4'd6, 4'd9, 14'd0), 1'b0, 2, 0);     // STORE
        run_instr(mk(3'd4, 3'b010, 4'd0, 4'd1, 4'd2, 14'd0), 1'b1, 0, 0);   // BRANCH taken
        run_instr(mk(3'd4, 3'b010, 4'd0, 4'd1, 4'd2, 14'd0), 1'b0, 0, 0);   // BRANCH not taken
        run_instr(mk(3'd5, 3'd3, 4'd4, 4'd4, 4'd4, 14'd1), 1'b0, 0, 0);     // illegal 101
        run_instr(mk(3'd6, 3'd1, 4'd4, 4'd4, 4'd4, 14'd1), 1'b1, 0, 0);     // illegal 110
        for (int i = 0; i < 24; i++) begin
            w        = $urandom;
            w[31:29] = 3'($urandom_range(0, 6));
            run_instr(w, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        run_halt();
        reset_dut(2);
        reset_mid_mem();
        run_instr(mk(3'd1, 3'b010, 4'd8, 4'd9, 4'd0, 14'd77), 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
